// File: rtl/traffic_ctrl_2way.sv
// Two-approach intersection controller: 1 Hz prescaler, A/B phases with all-red clearance,
// pedestrian shortening of A green, night flashing mode. Outputs registered except tick.
module traffic_ctrl_2way #(
    parameter int TICK_DIV  = 50000000,
    parameter int T_GREEN   = 30,
    parameter int T_YELLOW  = 3,
    parameter int T_ALLRED  = 2,
    parameter int T_PED_MIN = 5,
    parameter int TW        = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          night_mode,
    input  logic          ped_req,
    output logic [1:0]    led_a,
    output logic [1:0]    led_b,
    output logic [TW-1:0] timer_value,
    output logic          ped_walk,
    output logic          tick
);
    localparam int CW = $clog2(TICK_DIV);

    localparam logic [1:0] LED_RED = 2'b00;
    localparam logic [1:0] LED_GRN = 2'b01;
    localparam logic [1:0] LED_YEL = 2'b10;
    localparam logic [1:0] LED_OFF = 2'b11;

    typedef enum logic [2:0] {
        S_AG, S_AY, S_AR1, S_BG, S_BY, S_AR2, S_FLASH
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [TW-1:0]   timer_q, timer_d;
    logic            ped_pend_q, ped_pend_d;
    logic            flash_ph_q, flash_ph_d;
    logic            walk_q, walk_d;
    logic [1:0]      led_a_q, led_a_d, led_b_q, led_b_d;

    assign tick        = (cnt_q == CW'(TICK_DIV - 1));
    assign led_a       = led_a_q;
    assign led_b       = led_b_q;
    assign timer_value = timer_q;
    assign ped_walk    = walk_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            state_q    <= S_AR2;
            timer_q    <= TW'(T_ALLRED);
            ped_pend_q <= 1'b0;
            flash_ph_q <= 1'b0;
            walk_q     <= 1'b0;
            led_a_q    <= LED_RED;
            led_b_q    <= LED_RED;
        end else begin
            cnt_q      <= tick ? '0 : cnt_q + 1'b1;
            state_q    <= state_d;
            timer_q    <= timer_d;
            ped_pend_q <= ped_pend_d;
            flash_ph_q <= flash_ph_d;
            walk_q     <= walk_d;
            led_a_q    <= led_a_d;
            led_b_q    <= led_b_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        ped_pend_d = ped_pend_q | ped_req;
        flash_ph_d = flash_ph_q;
        walk_d     = walk_q;
        if (tick) begin
            if (state_q == S_FLASH) begin
                if (!night_mode) begin
                    state_d    = S_AR2;
                    timer_d    = TW'(T_ALLRED);
                    flash_ph_d = 1'b0;
                end else begin
                    flash_ph_d = ~flash_ph_q;
                end
            end else if (timer_q == TW'(1)) begin
                case (state_q)
                    S_AG: begin
                        state_d = S_AY;
                        timer_d = TW'(T_YELLOW);
                    end
                    S_AY: begin
                        state_d = S_AR1;
                        timer_d = TW'(T_ALLRED);
                    end
                    S_BG: begin
                        state_d = S_BY;
                        timer_d = TW'(T_YELLOW);
                        walk_d  = 1'b0;
                    end
                    S_BY: begin
                        state_d = S_AR2;
                        timer_d = TW'(T_ALLRED);
                    end
                    default: begin
                        // All-red expiry is the only point where night mode may take over.
                        if (night_mode) begin
                            state_d    = S_FLASH;
                            timer_d    = '0;
                            flash_ph_d = 1'b1;
                        end else if (state_q == S_AR1) begin
                            state_d    = S_BG;
                            timer_d    = TW'(T_GREEN);
                            walk_d     = ped_pend_q;
                            ped_pend_d = ped_req;
                        end else begin
                            state_d = S_AG;
                            timer_d = TW'(T_GREEN);
                        end
                    end
                endcase
            end else if (state_q == S_AG && ped_pend_q && timer_q > TW'(T_PED_MIN)) begin
                timer_d = TW'(T_PED_MIN);
            end else begin
                timer_d = timer_q - 1'b1;
            end
        end
    end

    always_comb begin
        led_a_d = LED_RED;
        led_b_d = LED_RED;
        case (state_d)
            S_AG:    led_a_d = LED_GRN;
            S_AY:    led_a_d = LED_YEL;
            S_BG:    led_b_d = LED_GRN;
            S_BY:    led_b_d = LED_YEL;
            S_FLASH: begin
                led_a_d = flash_ph_d ? LED_YEL : LED_OFF;
                led_b_d = flash_ph_d ? LED_YEL : LED_OFF;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_traffic_ctrl_2way.sv
// Bench for traffic_ctrl_2way: directed scenarios plus a randomized run against a phase-table model.
module tb_traffic_ctrl_2way;
    localparam int TICK_DIV = 4, T_GREEN = 5, T_YELLOW = 2, T_ALLRED = 1, T_PED_MIN = 2, TW = 6;

    logic clk = 1'b0, rst = 1'b1, night_mode = 1'b0, ped_req = 1'b0;
    logic [1:0] led_a, led_b;
    logic [TW-1:0] timer_value;
    logic ped_walk, tick;
    int total = 0, bad = 0;

    traffic_ctrl_2way #(.TICK_DIV(TICK_DIV), .T_GREEN(T_GREEN), .T_YELLOW(T_YELLOW),
                        .T_ALLRED(T_ALLRED), .T_PED_MIN(T_PED_MIN), .TW(TW)) dut (
        .clk(clk), .rst(rst), .night_mode(night_mode), .ped_req(ped_req),
        .led_a(led_a), .led_b(led_b), .timer_value(timer_value), .ped_walk(ped_walk), .tick(tick));

    always #5 clk = ~clk;

    // Reference: phase index into a table of durations and lamp codes, plus a flashing flag.
    int  dur[6] = '{T_GREEN, T_YELLOW, T_ALLRED, T_GREEN, T_YELLOW, T_ALLRED};
    int  la[6]  = '{1, 2, 0, 0, 0, 0};
    int  lb[6]  = '{0, 0, 0, 1, 2, 0};
    int  m_cnt = 0, m_idx = 5, m_rem = T_ALLRED;
    bit  m_flash = 0, m_fph = 0, m_pend = 0, m_walk = 0;

    always @(posedge clk) begin
        bit t, np;
        if (rst) begin
            m_cnt = 0; m_idx = 5; m_rem = T_ALLRED; m_flash = 0; m_fph = 0; m_pend = 0; m_walk = 0;
        end else begin
            t = (m_cnt == TICK_DIV - 1);
            m_cnt = t ? 0 : m_cnt + 1;
            np = m_pend | ped_req;
            if (t) begin
                if (m_flash) begin
                    if (!night_mode) begin m_flash = 0; m_idx = 5; m_rem = T_ALLRED; end
                    else m_fph = !m_fph;
                end else if (m_rem == 1) begin
                    if ((m_idx == 2 || m_idx == 5) && night_mode) begin
                        m_flash = 1; m_fph = 1;
                    end else begin
                        m_idx = (m_idx + 1) % 6;
                        m_rem = dur[m_idx];
                        if (m_idx == 3) begin m_walk = m_pend; np = ped_req; end
                        if (m_idx == 4) m_walk = 0;
                    end
                end else if (m_idx == 0 && m_pend && m_rem > T_PED_MIN) m_rem = T_PED_MIN;
                else m_rem = m_rem - 1;
            end
            m_pend = np;
        end
    end

    // Advance to the cycle just after the next tick; missing ticks count as a failure.
    task automatic wait_tick();
        bit seen = 0;
        for (int k = 0; k < 4 * TICK_DIV && !seen; k++) begin
            if (tick === 1'b1) seen = 1;
            @(negedge clk);
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL wait_tick: got no tick, required one within %0d cycles", 4 * TICK_DIV);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({led_a, led_b, timer_value, ped_walk, tick} !== {2'b00, 2'b00, 6'd1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state: got a=%b b=%b t=%0d w=%b tick=%b, need 00 00 1 0 0",
                     led_a, led_b, timer_value, ped_walk, tick);
        end
        rst = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            total++;
            if (tick !== ((i % 4) == 0)) begin
                bad++;
                $display("FAIL prescaler cycle %0d: got tick=%b need %b", i, tick, (i % 4) == 0);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_full_cycle();
        int et[16]  = '{5, 4, 3, 2, 1, 2, 1, 1, 5, 4, 3, 2, 1, 2, 1, 1};
        int ea[16]  = '{1, 1, 1, 1, 1, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        int eb[16]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 2, 2, 0};
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        wait_tick();
        for (int j = 0; j <= 16; j++) begin
            total++;
            if ({led_a, led_b, timer_value, ped_walk} !==
                {2'(ea[j % 16]), 2'(eb[j % 16]), 6'(et[j % 16]), 1'b0}) begin
                bad++;
                $display("FAIL full_cycle step %0d: got a=%b b=%b t=%0d w=%b, need a=%0d b=%0d t=%0d w=0",
                         j, led_a, led_b, timer_value, ped_walk, ea[j % 16], eb[j % 16], et[j % 16]);
            end
            if (j < 16) wait_tick();
        end
    endtask

    task automatic test_ped();
        ped_req = 1'b1; @(negedge clk); ped_req = 1'b0;
        wait_tick();
        total++;
        if (timer_value !== 6'd2 || led_a !== 2'b01) begin
            bad++; $display("FAIL ped_shorten: got t=%0d a=%b, need t=2 a=01", timer_value, led_a);
        end
        wait_tick(); wait_tick();
        total++;
        if (led_a !== 2'b10 || timer_value !== 6'd2 || ped_walk !== 1'b0) begin
            bad++; $display("FAIL ped_to_ay: got a=%b t=%0d w=%b, need 10 2 0", led_a, timer_value, ped_walk);
        end
        wait_tick(); wait_tick();
        total++;
        if (ped_walk !== 1'b0) begin bad++; $display("FAIL ped_ar1_walk: got %b need 0", ped_walk); end
        for (int i = 0; i < 5; i++) begin
            wait_tick();
            total++;
            if (ped_walk !== 1'b1 || led_b !== 2'b01 || timer_value !== 6'(5 - i)) begin
                bad++;
                $display("FAIL ped_bg_walk %0d: got w=%b b=%b t=%0d need 1 01 %0d",
                         i, ped_walk, led_b, timer_value, 5 - i);
            end
        end
        wait_tick();
        total++;
        if (ped_walk !== 1'b0 || led_b !== 2'b10) begin
            bad++; $display("FAIL ped_by_walk: got w=%b b=%b need 0 10", ped_walk, led_b);
        end
    endtask

    task automatic test_late_ped();
        repeat (3) wait_tick();               // BY1, AR2, AG5
        repeat (4) wait_tick();               // AG1
        repeat (3) @(negedge clk);
        total++;
        if (tick !== 1'b1 || timer_value !== 6'd1 || led_a !== 2'b01) begin
            bad++; $display("FAIL late_setup: got tick=%b t=%0d a=%b need 1 1 01", tick, timer_value, led_a);
        end
        ped_req = 1'b1; @(negedge clk); ped_req = 1'b0;
        total++;
        if (led_a !== 2'b10 || timer_value !== 6'd2) begin
            bad++; $display("FAIL late_ay: got a=%b t=%0d need 10 2", led_a, timer_value);
        end
        repeat (3) wait_tick();
        total++;
        if (ped_walk !== 1'b1 || led_b !== 2'b01) begin
            bad++; $display("FAIL late_walk: got w=%b b=%b need 1 01", ped_walk, led_b);
        end
        ped_req = 1'b1; @(negedge clk); ped_req = 1'b0;
        repeat (8) wait_tick();               // BG1 .. BY .. AR2 .. AG5
        total++;
        if (led_a !== 2'b01 || timer_value !== 6'd5 || ped_walk !== 1'b0) begin
            bad++; $display("FAIL second_ag: got a=%b t=%0d w=%b need 01 5 0", led_a, timer_value, ped_walk);
        end
        wait_tick();
        total++;
        if (timer_value !== 6'd2) begin bad++; $display("FAIL second_shorten: got t=%0d need 2", timer_value); end
        repeat (5) wait_tick();
        total++;
        if (ped_walk !== 1'b1 || led_b !== 2'b01 || timer_value !== 6'd5) begin
            bad++; $display("FAIL second_walk: got w=%b b=%b t=%0d need 1 01 5", ped_walk, led_b, timer_value);
        end
    endtask

    task automatic test_night();
        night_mode = 1'b1;
        repeat (4) wait_tick();
        total++;
        if (led_b !== 2'b01 || timer_value !== 6'd1) begin
            bad++; $display("FAIL night_bg_completes: got b=%b t=%0d need 01 1", led_b, timer_value);
        end
        repeat (3) wait_tick();
        total++;
        if ({led_a, led_b, timer_value} !== {2'b00, 2'b00, 6'd1}) begin
            bad++; $display("FAIL night_ar2: got a=%b b=%b t=%0d need 00 00 1", led_a, led_b, timer_value);
        end
        for (int i = 0; i < 4; i++) begin
            wait_tick();
            total++;
            if ({led_a, led_b, timer_value, ped_walk} !==
                {(i % 2 == 0) ? 4'b1010 : 4'b1111, 6'd0, 1'b0}) begin
                bad++;
                $display("FAIL flash %0d: got a=%b b=%b t=%0d w=%b", i, led_a, led_b, timer_value, ped_walk);
            end
        end
        night_mode = 1'b0;
        wait_tick();
        total++;
        if ({led_a, led_b, timer_value} !== {2'b00, 2'b00, 6'd1}) begin
            bad++; $display("FAIL flash_exit_ar2: got a=%b b=%b t=%0d need 00 00 1", led_a, led_b, timer_value);
        end
        wait_tick();
        total++;
        if (led_a !== 2'b01 || timer_value !== 6'd5) begin
            bad++; $display("FAIL flash_exit_ag: got a=%b t=%0d need 01 5", led_a, timer_value);
        end
    endtask

    task automatic test_reset_mid();
        repeat (8) wait_tick();               // AG4..AG1, AY2, AY1, AR1, BG5
        ped_req = 1'b1; @(negedge clk); ped_req = 1'b0;
        repeat (2) wait_tick();
        total++;
        if (led_b !== 2'b01 || timer_value !== 6'd3) begin
            bad++; $display("FAIL mid_setup: got b=%b t=%0d need 01 3", led_b, timer_value);
        end
        rst = 1'b1; @(negedge clk);
        total++;
        if ({led_a, led_b, timer_value, ped_walk, tick} !== {2'b00, 2'b00, 6'd1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL mid_reset: got a=%b b=%b t=%0d w=%b tick=%b need 00 00 1 0 0",
                     led_a, led_b, timer_value, ped_walk, tick);
        end
        rst = 1'b0;
        repeat (2) wait_tick();
        total++;
        if (led_a !== 2'b01 || timer_value !== 6'd4) begin
            bad++; $display("FAIL mid_pend_cleared: got a=%b t=%0d need 01 4", led_a, timer_value);
        end
    endtask

    task automatic test_random();
        rst = 1'b1; repeat (2) @(negedge clk); rst = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            logic [1:0] ea, eb;
            ea = m_flash ? (m_fph ? 2'b10 : 2'b11) : 2'(la[m_idx]);
            eb = m_flash ? (m_fph ? 2'b10 : 2'b11) : 2'(lb[m_idx]);
            total++;
            if ({led_a, led_b, timer_value, ped_walk, tick} !==
                {ea, eb, m_flash ? 6'd0 : 6'(m_rem), m_walk, 1'(m_cnt == TICK_DIV - 1)}) begin
                bad++;
                $display("FAIL random cycle %0d: got a=%b b=%b t=%0d w=%b tick=%b need a=%b b=%b t=%0d w=%b tick=%b",
                         c, led_a, led_b, timer_value, ped_walk, tick, ea, eb,
                         m_flash ? 0 : m_rem, m_walk, m_cnt == TICK_DIV - 1);
            end
            total++;
            if (led_a !== 2'b00 && led_b !== 2'b00 && !(led_a === led_b && led_a[1] === 1'b1)) begin
                bad++; $display("FAIL safety cycle %0d: got a=%b b=%b", c, led_a, led_b);
            end
            ped_req = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 149) == 0) night_mode = ~night_mode;
            @(negedge clk);
        end
        ped_req = 1'b0; night_mode = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_full_cycle();
        test_ped();
        test_late_ped();
        test_night();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
